// File: rtl/mixer_pkg.sv
// ---------------------------------------------------------------------------
// mixer_pkg
// Shared widths, constants and FSM encoding for the voice mixer and its
// saturating scaler.
// ---------------------------------------------------------------------------
package mixer_pkg;

  localparam int SAMPLE_W   = 16;  // voice / output sample width (signed)
  localparam int ACC_W      = 19;  // SAMPLE_W + log2(NUM_VOICES): cannot overflow
  localparam int VOL_W      = 8;   // master volume width (unsigned)
  localparam int VOL_SHIFT  = 7;   // post-multiply shift, 128 == unity
  localparam int VOL_UNITY  = 128;
  localparam int NUM_VOICES = 8;
  localparam int IDX_W      = 3;

  // acc (19b signed) times zero-extended volume (9b signed) fits in 28 bits
  localparam int PROD_W     = ACC_W + VOL_W + 1;

  localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = 16'h7FFF;  //  32767
  localparam logic [SAMPLE_W-1:0] SAMPLE_MIN = 16'h8000;  // -32768

  // status bit positions
  localparam int STATUS_DROP      = 0;  // input frame arrived while busy
  localparam int STATUS_OVERWRITE = 1;  // unconsumed output replaced

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2
  } state_t;

endpackage : mixer_pkg

// File: rtl/mixer_sat_scale.sv
// ---------------------------------------------------------------------------
// mixer_sat_scale
// Purely combinational: multiplies the signed voice sum by the unsigned
// master volume, arithmetic-shifts right by VOL_SHIFT (floor), and saturates
// the result to the signed SAMPLE_W range.
//
// Ports:
//   acc    in   ACC_W    signed accumulated voice sum
//   vol    in   VOL_W    unsigned master volume (128 = unity)
//   sample out  SAMPLE_W saturated, scaled sample
//   clip   out  1        high when saturation was applied
// ---------------------------------------------------------------------------
module mixer_sat_scale
  import mixer_pkg::*;
(
  input  logic [ACC_W-1:0]    acc,
  input  logic [VOL_W-1:0]    vol,
  output logic [SAMPLE_W-1:0] sample,
  output logic                clip
);

  localparam logic signed [PROD_W-1:0] MAX_EXT = {{(PROD_W-SAMPLE_W){1'b0}}, SAMPLE_MAX};
  localparam logic signed [PROD_W-1:0] MIN_EXT = {{(PROD_W-SAMPLE_W){1'b1}}, SAMPLE_MIN};

  logic signed [PROD_W-1:0] acc_ext;
  logic signed [PROD_W-1:0] vol_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;

  // Both operands widened to the product width up front so the multiply is
  // fully signed and the 28-bit result is exact.
  assign acc_ext = {{(PROD_W-ACC_W){acc[ACC_W-1]}}, acc};
  assign vol_ext = {{(PROD_W-VOL_W){1'b0}}, vol};
  assign prod    = acc_ext * vol_ext;
  assign shifted = prod >>> VOL_SHIFT;

  always_comb begin
    sample = shifted[SAMPLE_W-1:0];
    clip   = 1'b0;
    if (shifted > MAX_EXT) begin
      sample = SAMPLE_MAX;
      clip   = 1'b1;
    end else if (shifted < MIN_EXT) begin
      sample = SAMPLE_MIN;
      clip   = 1'b1;
    end
  end

endmodule : mixer_sat_scale

// File: rtl/voice_mixer.sv
// ---------------------------------------------------------------------------
// voice_mixer
// Captures eight voice samples on samples_in_ready, sums them serially (one
// voice per cycle), applies master volume with saturation and presents the
// result on a valid/ready output. Sticky status flags record dropped input
// frames and overwritten outputs.
//
// Optional build macro: VOICE_MIXER_CLIP_COUNT_EN adds a saturating 16-bit
// clip_count output counting saturated results.
//
// Ports:
//   clk                 in   clock
//   reset               in   asynchronous, active-low reset
//   samples_in_ready    in   one-cycle pulse, sample_in1..8 valid
//   sample_in1..8       in   16b signed voice samples
//   master_volume       in   8b unsigned, 128 = unity
//   out_ready           in   consumer accepts sample_out this edge
//   clear_status        in   pulse, clears status flags
//   sample_out          out  16b signed mixed sample
//   out_valid           out  sample_out holds an unconsumed result
//   busy                out  FSM not in IDLE
//   clipped             out  last produced sample was saturated
//   status              out  [0] frame dropped, [1] output overwritten
//   clip_count          out  16b saturated-result count (optional)
// ---------------------------------------------------------------------------
module voice_mixer
  import mixer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        samples_in_ready,
  input  logic [15:0] sample_in1,
  input  logic [15:0] sample_in2,
  input  logic [15:0] sample_in3,
  input  logic [15:0] sample_in4,
  input  logic [15:0] sample_in5,
  input  logic [15:0] sample_in6,
  input  logic [15:0] sample_in7,
  input  logic [15:0] sample_in8,
  input  logic [7:0]  master_volume,
  input  logic        out_ready,
  input  logic        clear_status,
  output logic [15:0] sample_out,
  output logic        out_valid,
  output logic        busy,
  output logic        clipped,
  output logic [1:0]  status
`ifdef VOICE_MIXER_CLIP_COUNT_EN
  ,
  output logic [15:0] clip_count
`endif
);

  state_t state_q, state_d;

  logic [SAMPLE_W-1:0] voice_q [NUM_VOICES];
  logic [SAMPLE_W-1:0] voice_d [NUM_VOICES];
  logic [SAMPLE_W-1:0] sample_in [NUM_VOICES];
  logic [VOL_W-1:0]    vol_q, vol_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic [SAMPLE_W-1:0] sample_out_q, sample_out_d;
  logic                out_valid_q, out_valid_d;
  logic                clipped_q, clipped_d;
  logic [1:0]          status_q, status_d;

  logic [SAMPLE_W-1:0] scaled_sample;
  logic                scaled_clip;
  logic                scale_done;
  logic [ACC_W-1:0]    voice_ext;

  assign sample_in[0] = sample_in1;
  assign sample_in[1] = sample_in2;
  assign sample_in[2] = sample_in3;
  assign sample_in[3] = sample_in4;
  assign sample_in[4] = sample_in5;
  assign sample_in[5] = sample_in6;
  assign sample_in[6] = sample_in7;
  assign sample_in[7] = sample_in8;

  mixer_sat_scale u_sat_scale (
    .acc    (acc_q),
    .vol    (vol_q),
    .sample (scaled_sample),
    .clip   (scaled_clip)
  );

  assign scale_done = (state_q == SCALE);
  assign voice_ext  = {{(ACC_W-SAMPLE_W){voice_q[idx_q][SAMPLE_W-1]}}, voice_q[idx_q]};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (samples_in_ready) state_d = ACCUM;
      ACCUM:   if (idx_q == IDX_W'(NUM_VOICES - 1)) state_d = SCALE;
      SCALE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs / datapath ----------------
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) voice_d[i] = voice_q[i];
    vol_d        = vol_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    sample_out_d = sample_out_q;
    out_valid_d  = out_valid_q;
    clipped_d    = clipped_q;
    status_d     = clear_status ? 2'b00 : status_q;

    case (state_q)
      IDLE: begin
        if (samples_in_ready) begin
          for (int i = 0; i < NUM_VOICES; i++) voice_d[i] = sample_in[i];
          vol_d = master_volume;
          acc_d = '0;
          idx_d = '0;
        end
      end
      ACCUM: begin
        acc_d = acc_q + voice_ext;
        idx_d = idx_q + 1'b1;  // wraps back to 0 after the last voice
      end
      default: ;
    endcase

    // A frame arriving while the pipeline is occupied is discarded.
    if (samples_in_ready && (state_q != IDLE)) begin
      status_d[STATUS_DROP] = 1'b1;
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A new result wins over a same-edge accept; it only counts as an
    // overwrite when the previous result was still unaccepted.
    if (scale_done) begin
      sample_out_d = scaled_sample;
      clipped_d    = scaled_clip;
      out_valid_d  = 1'b1;
      if (out_valid_q && !out_ready) begin
        status_d[STATUS_OVERWRITE] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VOICES; i++) voice_q[i] <= '0;
      vol_q        <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
      clipped_q    <= 1'b0;
      status_q     <= 2'b00;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) voice_q[i] <= voice_d[i];
      vol_q        <= vol_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      sample_out_q <= sample_out_d;
      out_valid_q  <= out_valid_d;
      clipped_q    <= clipped_d;
      status_q     <= status_d;
    end
  end

`ifdef VOICE_MIXER_CLIP_COUNT_EN
  logic [15:0] clip_count_q, clip_count_d;

  // Clear takes priority over the old value but a same-edge clip still
  // counts, giving 1; the count sticks at all-ones instead of wrapping.
  always_comb begin
    clip_count_d = clear_status ? 16'd0 : clip_count_q;
    if (scale_done && scaled_clip && (clip_count_d != 16'hFFFF)) begin
      clip_count_d = clip_count_d + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clip_count_q <= 16'd0;
    end else begin
      clip_count_q <= clip_count_d;
    end
  end

  assign clip_count = clip_count_q;
`endif

  assign sample_out = sample_out_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != IDLE);
  assign clipped    = clipped_q;
  assign status     = status_q;

endmodule : voice_mixer

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
Downstream consumer of the per-voice dynamics stage. Captures the eight gain/decay-scaled voice samples on each `samples_in_ready` pulse and sums them serially, one voice per cycle. Applies a master volume, saturates to 16-bit signed, and presents the mixed sample to the codec/DAC interface over a valid/ready handshake. Sticky status flags report dropped input frames and overwritten output samples.

Parameters:
- SAMPLE_W, 16, width of voice and output samples (signed)
- ACC_W, 19, accumulator width (SAMPLE_W + log2(8)); must never overflow
- VOL_W, 8, master volume width (unsigned); 128 = unity gain
- VOL_SHIFT, 7, right-shift applied after the volume multiply

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- samples_in_ready  in  1  one-cycle pulse: sample_in1..8 valid
- sample_in1 .. sample_in8  in  16 each  signed voice samples from the dynamics stage
- master_volume  in  8  unsigned; out = sum*vol/128
- out_ready  in  1  consumer accepts sample_out this edge
- clear_status  in  1  pulse: clears status flags
- sample_out  out  16  signed mixed sample
- out_valid  out  1  sample_out holds an unconsumed result
- busy  out  1  high in any state other than IDLE
- clipped  out  1  last produced sample was saturated
- status  out  2  sticky: [0] input frame dropped, [1] output overwritten before accept

Behaviour:
- Reset (async, reset==0): state=IDLE; sample_out=0; out_valid=0; clipped=0; status=0; accumulator=0; voice index=0.
- FSM states: IDLE, ACCUM, SCALE.
- IDLE:
  - samples_in_ready=1 at an edge -> latch all 8 samples and master_volume into internal registers; acc=0; idx=0; next state ACCUM.
- ACCUM:
  - Each edge: acc += sign_extend(reg[idx]); idx++.
  - After idx==7 is accumulated -> SCALE. Takes exactly 8 edges.
- SCALE:
  - prod = acc (signed 19b) * {0, vol} (signed 9b) -> 28b signed; shifted = prod >>> 7 (arithmetic, floor).
  - Saturate shifted to [-32768, 32767].
  - Register sample_out; set clipped=1 iff saturation occurred; out_valid=1. Next state IDLE.
- Latency: out_valid rises on the 10th rising edge after (and counting) the edge that samples samples_in_ready. Throughput: one frame per 10 cycles minimum.
- Input handshake:
  - samples_in_ready while busy -> frame ignored; status[0]=1.
  - The in-flight computation is unaffected.
- Output handshake:
  - out_valid && out_ready at an edge -> out_valid=0.
  - SCALE completing on the same edge -> out_valid stays 1 and sample_out takes the new value; no overwrite flagged.
  - SCALE completing while out_valid=1 && out_ready=0 -> sample_out overwritten; status[1]=1.
- sample_out holds its value when out_valid=0.
- clear_status clears both flags. A set condition on the same edge wins.
- clipped updates only in SCALE.
- Reset asserted mid-frame aborts the frame; no output is produced for it.

Optional Feature:
- VOICE_MIXER_CLIP_COUNT_EN
- Defined:
  - Adds output port clip_count [15:0].
  - Increments on every SCALE that saturates; holds at 16'hFFFF (no wrap).
  - Reset to 0; cleared by clear_status. An increment on the same edge as clear_status yields 1.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package mixer_pkg holds:
  - SAMPLE_W, ACC_W, VOL_W, VOL_SHIFT
  - VOL_UNITY=128
  - SAMPLE_MAX/SAMPLE_MIN constants
  - FSM state typedef (IDLE/ACCUM/SCALE)
  - status bit index constants
- One sub-module: mixer_sat_scale (combinational: acc, vol -> saturated sample, clip flag). The FSM, capture registers and handshake stay in voice_mixer.

Test Plan:
1. Inputs 0,600,1170,1190,-7768,-15173,1170,1170 with vol=128 -> sample_out=-17641, clipped=0, out_valid at the 10th edge; with vol=127 -> -17504.
2. All inputs 32767, vol=128 -> 32767, clipped=1. All inputs -32768, vol=128 -> -32768, clipped=1 (sum -262144 does not overflow the accumulator).
3. All inputs 1000: vol=64 -> 4000; vol=0 -> 0; vol=255 -> 15937, no clip.
4. out_ready held 0, two frames 12 cycles apart -> sample_out = second result, status=2'b10; clear_status -> status=0.
5. Second samples_in_ready pulse 3 cycles after the first -> status[0]=1 and the first result is correct; pulse on the same edge out_valid drops with out_ready=1 -> no flags.
6. reset pulled low during ACCUM -> all outputs 0 immediately; out_valid stays 0 until a new frame.
